// File: rtl/accuracy_tracker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : accuracy_tracker_pkg                                            |
// | Purpose  : Shared types and constants for the accuracy tracker: run-level  |
// |            state encoding, per-mille scale and divider latency derivation. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package accuracy_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DIVIDE  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int PERMILLE_SCALE = 1000;

  // correct*1000 needs 10 extra bits over the counter (1000 < 2^10).
  localparam int SCALE_EXTRA_BITS = 10;

  // One quotient bit per cycle over the whole scaled numerator.
  function automatic int div_cycles(input int cnt_bit);
    return cnt_bit + SCALE_EXTRA_BITS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accuracy_tracker_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : accuracy_divider                                                |
// | Purpose  : Unsigned restoring divider, one quotient bit per cycle, MSB     |
// |            first, fixed latency of NUM_W cycles after start.               |
// | Ports    : clk, reset_b (async, active-low)                                |
// |            start     - load operands and begin (ignored when abort high)   |
// |            abort     - cancel any division in progress                     |
// |            numerator - NUM_W-bit dividend                                  |
// |            denominator - DEN_W-bit divisor (must be non-zero)              |
// |            done      - high during the final iteration cycle               |
// |            quotient  - full quotient, valid while done is high             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module accuracy_divider #(
  parameter int NUM_W = 24,
  parameter int DEN_W = 14
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int ITER_W = $clog2(NUM_W + 1);

  logic              active_q, active_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [NUM_W-1:0]  quo_q, quo_d;
  logic [DEN_W-1:0]  rem_q, rem_d;
  logic [DEN_W-1:0]  den_q, den_d;
  logic [DEN_W:0]    trial;
  logic              fits;
  logic              unused_quo_msb;

  // The last quotient bit is resolved combinationally so the consumer can
  // capture the result on the same edge that ends the final iteration.
  always_comb begin
    trial    = {rem_q, num_q[NUM_W-1]};
    fits     = (trial >= {1'b0, den_q});
    quotient = {quo_q[NUM_W-2:0], fits};
    done     = active_q && (iter_q == ITER_W'(1));

    active_d = active_q;
    iter_d   = iter_q;
    num_d    = num_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    den_d    = den_q;

    if (abort) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      iter_d   = ITER_W'(NUM_W);
      num_d    = numerator;
      den_d    = denominator;
      quo_d    = '0;
      rem_d    = '0;
    end else if (active_q) begin
      // Remainder stays below the divisor, so DEN_W bits always suffice.
      rem_d  = fits ? DEN_W'(trial - {1'b0, den_q}) : trial[DEN_W-1:0];
      num_d  = num_q << 1;
      quo_d  = quotient;
      iter_d = iter_q - ITER_W'(1);
      if (done) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      active_q <= 1'b0;
      iter_q   <= '0;
      num_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      den_q    <= '0;
    end else begin
      active_q <= active_d;
      iter_q   <= iter_d;
      num_q    <= num_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      den_q    <= den_d;
    end
  end

  assign unused_quo_msb = quo_q[NUM_W-1];

endmodule
`default_nettype wire

// File: rtl/accuracy_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : accuracy_tracker                                                |
// | Purpose  : Counts evaluated / correctly classified images over a run and   |
// |            computes floor(correct*1000/total) with a multi-cycle divider.  |
// | Ports    : clk, reset_b (async, active-low)                                |
// |            start_run, finish_run      - run control pulses                 |
// |            end_state3, matched, target_label_onehot - compare result       |
// |            class_sel                  - per-class readout select           |
// |            total_count, correct_count, class_hit_count, accuracy_permille  |
// |            busy (COLLECT/DIVIDE), run_done (one-cycle result pulse)        |
// | Config   : PER_CLASS_STATS_EN - build NOUT per-class hit counters; when    |
// |            undefined class_hit_count is 0 and class_sel is unused.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module accuracy_tracker
  import accuracy_tracker_pkg::*;
#(
  parameter int NOUT       = 10,
  parameter int NUM_IMAGES = 10000,
  parameter int CNT_BIT    = 14,
  parameter int ACC_BIT    = 10
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               start_run,
  input  logic               finish_run,
  input  logic               end_state3,
  input  logic               matched,
  input  logic [NOUT-1:0]    target_label_onehot,
  input  logic [3:0]         class_sel,
  output logic [CNT_BIT-1:0] total_count,
  output logic [CNT_BIT-1:0] correct_count,
  output logic [CNT_BIT-1:0] class_hit_count,
  output logic [ACC_BIT-1:0] accuracy_permille,
  output logic               busy,
  output logic               run_done
);

  localparam int NUM_W = div_cycles(CNT_BIT);

  state_e             state_q, state_d;
  logic [CNT_BIT-1:0] total_q, total_d;
  logic [CNT_BIT-1:0] correct_q, correct_d;
  logic [ACC_BIT-1:0] acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               run_done_q, run_done_d;

  logic               count_evt;
  logic               div_start, div_abort, div_done;
  logic [NUM_W-1:0]   correct_ext, numerator, div_quo;
  logic               unused_div_quo;

  // start_run takes priority over a coincident compare result.
  assign count_evt = (state_q == ST_COLLECT) && end_state3 && !start_run;

  // Scaled numerator built from the post-increment count so the divider can
  // be loaded on the same edge that leaves COLLECT.
  assign correct_ext = NUM_W'(correct_d);
  assign numerator   = (correct_ext << 10) - (correct_ext << 4) - (correct_ext << 3);

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    correct_d  = correct_q;
    acc_d      = acc_q;
    run_done_d = 1'b0;
    div_start  = 1'b0;
    div_abort  = 1'b0;

    if (start_run) begin
      state_d   = ST_COLLECT;
      total_d   = '0;
      correct_d = '0;
      acc_d     = '0;
      div_abort = 1'b1;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (count_evt) begin
            total_d = total_q + CNT_BIT'(1);
            if (matched) correct_d = correct_q + CNT_BIT'(1);
          end
          if ((total_d == CNT_BIT'(NUM_IMAGES)) || finish_run) begin
            if (total_d == '0) begin
              // Empty run: nothing to divide, report 0 immediately.
              state_d    = ST_DONE;
              acc_d      = '0;
              run_done_d = 1'b1;
            end else begin
              state_d   = ST_DIVIDE;
              div_start = 1'b1;
            end
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            state_d    = ST_DONE;
            acc_d      = div_quo[ACC_BIT-1:0];
            run_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == ST_COLLECT) || (state_d == ST_DIVIDE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= ST_IDLE;
      total_q    <= '0;
      correct_q  <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      run_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      correct_q  <= correct_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      run_done_q <= run_done_d;
    end
  end

  accuracy_divider #(
    .NUM_W (NUM_W),
    .DEN_W (CNT_BIT)
  ) u_divider (
    .clk         (clk),
    .reset_b     (reset_b),
    .start       (div_start),
    .abort       (div_abort),
    .numerator   (numerator),
    .denominator (total_d),
    .done        (div_done),
    .quotient    (div_quo)
  );

  assign unused_div_quo = ^div_quo[NUM_W-1:ACC_BIT];

`ifdef PER_CLASS_STATS_EN
  logic [CNT_BIT-1:0] class_cnt_q [NOUT];
  logic [CNT_BIT-1:0] class_cnt_d [NOUT];
  logic               label_onehot;

  // A malformed label still counts toward total/correct but no class.
  assign label_onehot = (target_label_onehot != '0) &&
                        ((target_label_onehot & (target_label_onehot - NOUT'(1))) == '0);

  always_comb begin
    class_hit_count = '0;
    for (int i = 0; i < NOUT; i++) begin
      class_cnt_d[i] = class_cnt_q[i];
      if (start_run)
        class_cnt_d[i] = '0;
      else if (count_evt && matched && label_onehot && target_label_onehot[i])
        class_cnt_d[i] = class_cnt_q[i] + CNT_BIT'(1);
      // Out-of-range selects match no entry and read 0.
      if (class_sel == 4'(i)) class_hit_count = class_cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NOUT; i++) class_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NOUT; i++) class_cnt_q[i] <= class_cnt_d[i];
    end
  end
`else
  logic unused_class_inputs;

  assign class_hit_count     = '0;
  assign unused_class_inputs = ^{class_sel, target_label_onehot};
`endif

  assign total_count       = total_q;
  assign correct_count     = correct_q;
  assign accuracy_permille = acc_q;
  assign busy              = busy_q;
  assign run_done          = run_done_q;

endmodule
`default_nettype wire

// File: tb/tb_accuracy_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_accuracy_tracker                                             |
// | Purpose  : Self-checking bench for accuracy_tracker (NUM_IMAGES = 4):      |
// |            table-driven run vectors plus hand sequences for abort.         |
// |            Class expectations follow PER_CLASS_STATS_EN.                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_accuracy_tracker;

  localparam int NOUT       = 10;
  localparam int NUM_IMAGES = 4;
  localparam int CNT_BIT    = 14;
  localparam int ACC_BIT    = 10;
  localparam int DIV_CYCLES = CNT_BIT + 10;

  logic               clk;
  logic               reset_b;
  logic               start_run;
  logic               finish_run;
  logic               end_state3;
  logic               matched;
  logic [NOUT-1:0]    target_label_onehot;
  logic [3:0]         class_sel;
  logic [CNT_BIT-1:0] total_count;
  logic [CNT_BIT-1:0] correct_count;
  logic [CNT_BIT-1:0] class_hit_count;
  logic [ACC_BIT-1:0] accuracy_permille;
  logic               busy;
  logic               run_done;

  accuracy_tracker #(
    .NOUT       (NOUT),
    .NUM_IMAGES (NUM_IMAGES),
    .CNT_BIT    (CNT_BIT),
    .ACC_BIT    (ACC_BIT)
  ) dut (
    .clk                 (clk),
    .reset_b             (reset_b),
    .start_run           (start_run),
    .finish_run          (finish_run),
    .end_state3          (end_state3),
    .matched             (matched),
    .target_label_onehot (target_label_onehot),
    .class_sel           (class_sel),
    .total_count         (total_count),
    .correct_count       (correct_count),
    .class_hit_count     (class_hit_count),
    .accuracy_permille   (accuracy_permille),
    .busy                (busy),
    .run_done            (run_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;      // start_run
    int fin;     // finish_run
    int es3;     // end_state3
    int m;       // matched
    int oh;      // target_label_onehot
    int et;      // expected total_count
    int ec;      // expected correct_count
    int eb;      // expected busy
    int ed;      // expected run_done
    int wt;      // wait for run_done after this vector
    int eacc;    // expected accuracy when ed or wt
  } vec_t;

  vec_t vecs [17];
  int   n_cmp;
  int   n_err;

`ifdef PER_CLASS_STATS_EN
  localparam int CLS_EN = 1;
`else
  localparam int CLS_EN = 0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are driven just after a rising edge and cleared after the next.
  task automatic step(input int st, input int fin, input int es3, input int m, input int oh);
    start_run           = st[0];
    finish_run          = fin[0];
    end_state3          = es3[0];
    matched             = m[0];
    target_label_onehot = NOUT'(oh);
    @(posedge clk);
    #1;
    start_run  = 1'b0;
    finish_run = 1'b0;
    end_state3 = 1'b0;
    matched    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_acc);
    int got;
    got = -1;
    for (int k = 1; k <= DIV_CYCLES + 4; k++) begin
      step(0, 0, 0, 0, 0);
      if (run_done) begin
        got = k;
        break;
      end
    end
    chk({name, "_div_latency"}, got, DIV_CYCLES);
    chk({name, "_acc"}, int'(accuracy_permille), exp_acc);
    chk({name, "_busy_at_done"}, int'(busy), 0);
  endtask

  task automatic chk_class(input string name, input int sel, input int exp);
    class_sel = 4'(sel);
    #1;
    chk(name, int'(class_hit_count), exp);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    string tag;
    for (int i = lo; i <= hi; i++) begin
      step(vecs[i].st, vecs[i].fin, vecs[i].es3, vecs[i].m, vecs[i].oh);
      tag = $sformatf("v%0d", i);
      chk({tag, "_total"}, int'(total_count), vecs[i].et);
      chk({tag, "_correct"}, int'(correct_count), vecs[i].ec);
      chk({tag, "_busy"}, int'(busy), vecs[i].eb);
      chk({tag, "_run_done"}, int'(run_done), vecs[i].ed);
      if (vecs[i].ed != 0) chk({tag, "_acc"}, int'(accuracy_permille), vecs[i].eacc);
      if (vecs[i].wt != 0) wait_done(tag, vecs[i].eacc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen_done;
    n_cmp = 0;
    n_err = 0;

    //              st fin es3 m  oh   et ec eb ed wt eacc
    // Run A: 4 events, matched 1,0,1,1 -> 750; then an event in DONE
    vecs[0]  = '{1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 1, 8,   1, 1, 1, 0, 0, 0};
    vecs[2]  = '{0, 0, 1, 0, 8,   2, 1, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 8,   3, 2, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 1, 128, 4, 3, 1, 0, 1, 750};
    vecs[5]  = '{0, 0, 1, 1, 8,   4, 3, 0, 0, 0, 0};
    // Run B: start with coincident event (dropped), 1,1,0 then finish -> 666
    vecs[6]  = '{1, 0, 1, 1, 8,   0, 0, 1, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 1, 2,   1, 1, 1, 0, 0, 0};
    vecs[8]  = '{0, 0, 1, 1, 2,   2, 2, 1, 0, 0, 0};
    vecs[9]  = '{0, 0, 1, 0, 4,   3, 2, 1, 0, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 0,   3, 2, 1, 0, 1, 666};
    // Run C: empty run -> straight to DONE, accuracy 0, single pulse
    vecs[11] = '{1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    // Run D: non-one-hot label, then event coincident with finish -> 1000
    vecs[14] = '{1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0};
    vecs[15] = '{0, 0, 1, 1, 3,   1, 1, 1, 0, 0, 0};
    vecs[16] = '{0, 1, 1, 1, 8,   2, 2, 1, 0, 1, 1000};

    reset_b             = 1'b0;
    start_run           = 1'b0;
    finish_run          = 1'b0;
    end_state3          = 1'b0;
    matched             = 1'b0;
    target_label_onehot = '0;
    class_sel           = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_total", int'(total_count), 0);
    chk("rst_correct", int'(correct_count), 0);
    chk("rst_acc", int'(accuracy_permille), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_run_done", int'(run_done), 0);
    chk("rst_class", int'(class_hit_count), 0);
    reset_b = 1'b1;
    @(posedge clk);
    #1;

    run_vecs(0, 5);
    chk_class("runA_class3", 3, 2 * CLS_EN);
    chk_class("runA_class7", 7, 1 * CLS_EN);
    chk_class("runA_class12", 12, 0);
    chk_class("runA_class0", 0, 0);

    run_vecs(6, 16);
    chk_class("runD_class3", 3, 1 * CLS_EN);
    chk_class("runD_class0", 0, 0);
    chk_class("runD_class1", 1, 0);

    // Restart while the divider is running: no result, fresh COLLECT.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 8);
    chk("abort_in_divide_busy", int'(busy), 1);
    repeat (5) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("abort_total", int'(total_count), 0);
    chk("abort_correct", int'(correct_count), 0);
    chk("abort_busy", int'(busy), 1);
    chk("abort_acc", int'(accuracy_permille), 0);
    chk_class("abort_class3", 3, 0);
    seen_done = 0;
    for (int i = 0; i < DIV_CYCLES + 4; i++) begin
      step(0, 0, 0, 0, 0);
      if (run_done) seen_done = 1;
    end
    chk("abort_no_run_done", seen_done, 0);
    chk("abort_still_collect", int'(busy), 1);
    step(0, 0, 1, 1, 8);
    step(0, 0, 1, 0, 8);
    step(0, 0, 1, 0, 8);
    step(0, 0, 1, 0, 8);
    chk("after_abort_total", int'(total_count), 4);
    chk("after_abort_correct", int'(correct_count), 1);
    wait_done("after_abort", 250);
    step(0, 0, 0, 0, 0);
    chk("after_abort_pulse_clear", int'(run_done), 0);
    chk("after_abort_acc_hold", int'(accuracy_permille), 250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accuracy_tracker.md
# accuracy_tracker

Downstream consumer of the classification compare stage. Counts evaluated images and correct predictions across a test run, then computes accuracy in per-mille with a multi-cycle restoring divider. Sits after the one-hot compare block and drives the run-level result and status outputs.

## Interface
- NOUT, 10, number of output classes
- NUM_IMAGES, 10000, images per run; the run ends automatically when this count is reached
- CNT_BIT, 14, counter width; must satisfy 2^CNT_BIT > NUM_IMAGES
- ACC_BIT, 10, accuracy output width (0..1000)

- clk  in  1  clock
- reset_b  in  1  reset, asynchronous, active-low
- start_run  in  1  pulse; clears all statistics and begins collection
- finish_run  in  1  pulse; ends collection early with the current counts
- end_state3  in  1  one-cycle pulse from compare: result valid
- matched  in  1  prediction equals target; sampled with end_state3
- target_label_onehot  in  NOUT  target class; sampled with end_state3
- class_sel  in  4  per-class readout select
- total_count  out  CNT_BIT  images evaluated
- correct_count  out  CNT_BIT  images matched
- class_hit_count  out  CNT_BIT  correct count for class class_sel
- accuracy_permille  out  ACC_BIT  floor(correct*1000/total)
- busy  out  1  high in COLLECT and DIVIDE
- run_done  out  1  one-cycle pulse when accuracy_permille becomes valid

## Operation
- States: IDLE, COLLECT, DIVIDE, DONE. Reset: IDLE; all counters, accuracy_permille, run_done and busy are 0.
- IDLE/DONE + start_run: clear counters and accuracy, go to COLLECT.
- COLLECT + end_state3: total_count+1; correct_count+1 if matched.
- COLLECT: if the increment makes total_count == NUM_IMAGES, go to DIVIDE on the same edge.
- COLLECT + finish_run: go to DIVIDE with the current counts. If total_count == 0, go straight to DONE with accuracy 0.
- Same cycle finish_run + end_state3: count the event first, then go to DIVIDE.
- start_run in any state, including COLLECT and DIVIDE, restarts the run: counters clear and the division aborts. start_run together with end_state3: start wins and the event is dropped.
- end_state3 outside COLLECT: ignored. finish_run outside COLLECT: ignored.
- Numerator = correct*1000, formed as (c<<10)-(c<<4)-(c<<3), width CNT_BIT+10. Unsigned restoring division by total_count. The low ACC_BIT bits of the quotient are kept.
- DONE: results are held until the next start_run.
- Counters never exceed NUM_IMAGES; there is no wrap-around.
- A target_label_onehot value that is not one-hot is counted in total and correct only; no class counter increments.

## Timing
- Counters update on the edge after the end_state3 cycle. Back-to-back end_state3 pulses are accepted every cycle.
- DIVIDE lasts exactly DIV_CYCLES = CNT_BIT+10 cycles: one quotient bit per cycle, MSB first.
- run_done is high for the first DONE cycle only. accuracy_permille updates on that same edge.
- busy falls on the edge that enters DONE.
- class_hit_count is a combinational mux of registers. class_sel >= NOUT gives 0.

## Configuration
- PER_CLASS_STATS_EN defined: NOUT counters of CNT_BIT bits. On a counted event with matched high, the counter for the set bit of target_label_onehot increments. All class counters clear on start_run.
- Not defined: no class counters are built. class_hit_count is tied to 0 and class_sel is unused. Ports are unchanged.

## Structure
- Shared package: state enum (IDLE/COLLECT/DIVIDE/DONE), DIV_CYCLES derivation, PERMILLE_SCALE = 1000 constant.
- Sub-module accuracy_divider: start/done handshake, restoring unsigned divider parameterized by numerator and denominator widths, fixed latency. The top-level FSM waits on its done.

## Test plan
- NUM_IMAGES=4; 4 end_state3 pulses with matched 1,0,1,1 -> total=4, correct=3; DIVIDE lasts DIV_CYCLES; run_done pulse; accuracy_permille=750.
- NUM_IMAGES=10; 3 events with matched 1,1,0, then finish_run -> accuracy=666 (floor).
- start_run then immediate finish_run with no events -> DONE next edge, accuracy=0, run_done pulses once.
- start_run mid-DIVIDE -> no run_done; counters=0; state COLLECT; a later full run gives correct accuracy.
- start_run coincident with end_state3 (matched=1) in COLLECT -> total=0 afterwards; end_state3 in DONE -> counts unchanged.
- PER_CLASS_STATS_EN: matched events with target classes 3,3,7 and one mismatch on class 3 -> class_sel=3 reads 2, class_sel=7 reads 1, class_sel=12 reads 0. Without the macro: all reads 0.
